// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage that feeds the decode logic. A byte-addressed PC indexes a flat
// instruction memory bus. Fetched words, each tagged with its PC, are buffered
// in a small prefetch FIFO. The FIFO head is presented to decode over a
// valid/ready handshake. A taken branch or jump (redirect) flushes the FIFO and
// reloads the PC.
//
// Optional feature macro: FETCH_PERF_CNT_EN. When it is defined, the unit adds
// saturating performance counters (fetch_count, stall_count, flush_count).
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 asynchronous active-high reset
//   instruction_stream  flat memory; word i = bits [32*i+31:32*i]
//   redirect_valid      branch/jump taken: flush and reload the PC
//   redirect_pc         new fetch byte address (bits [1:0] ignored)
//   instr_ready         decode accepts an instruction this cycle
//   instr_valid         instr/instr_pc hold a valid instruction
//   instr               instruction word at the FIFO head (0 when empty)
//   instr_pc            byte address of instr (0 when empty)
//   fetch_done          PC is past the end of the stream and the FIFO is empty
//   fetch_count         (FETCH_PERF_CNT_EN) pushes into the FIFO
//   stall_count         (FETCH_PERF_CNT_EN) cycles with instr_valid && !instr_ready
//   flush_count         (FETCH_PERF_CNT_EN) redirects
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int          NUM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [32*NUM_WORDS-1:0] instruction_stream,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    input  logic                   instr_ready,
    output logic                   instr_valid,
    output logic [31:0]            instr,
    output logic [31:0]            instr_pc,
    output logic                   fetch_done
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            fetch_count,
    output logic [31:0]            stall_count,
    output logic [15:0]            flush_count
`endif
);

    localparam int             IDX_W    = $clog2(NUM_WORDS);
    localparam int             PTR_W    = $clog2(FIFO_DEPTH);
    localparam int             CNT_W    = PTR_W + 1;
    localparam logic [32:0]    PC_LIMIT = 33'(4 * NUM_WORDS);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [31:0]       pc;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic [31:0]       fifo_instr_p0 [FIFO_DEPTH];
    logic [31:0]       fifo_pc_p0    [FIFO_DEPTH];

    logic              in_range;
    logic              not_empty;
    logic              pop;
    logic              push;
    logic [IDX_W-1:0]  word_idx;
    logic [31:0]       fetch_word;

    // The compare is one bit wider so that 4*NUM_WORDS cannot overflow.
    assign in_range   = ({1'b0, pc} < PC_LIMIT);
    assign word_idx   = pc[IDX_W+1:2];
    assign fetch_word = instruction_stream[{word_idx, 5'b00000} +: 32];

    assign not_empty  = (count != '0);
    // A redirect in flight makes the head stale, so it is hidden from decode.
    assign instr_valid = not_empty && !redirect_valid;
    assign pop         = instr_valid && instr_ready;
    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign push        = !redirect_valid && in_range && ((count < DEPTH_C) || pop);

    assign instr      = not_empty ? fifo_instr_p0[head] : '0;
    assign instr_pc   = not_empty ? fifo_pc_p0[head]    : '0;
    assign fetch_done = !in_range && !not_empty;

    // Control state: PC, occupancy and pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (redirect_valid) begin
            pc    <= redirect_pc & 32'hFFFF_FFFC;
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (push) begin
                pc   <= pc + 32'd4;
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Prefetch storage stage p0; occupancy gates the outputs, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_p0[tail] <= fetch_word;
            fifo_pc_p0[tail]    <= pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (push)                       fetch_count <= sat_inc32(fetch_count);
            if (instr_valid && !instr_ready) stall_count <= sat_inc32(stall_count);
            if (redirect_valid)             flush_count <= sat_inc16(flush_count);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. Stream words 0..2 carry the given
// instructions; every other word i holds {16'hC0DE, i[15:0]}, so any fetched
// word identifies its own address.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int NW = 1024;

    logic              clk;
    logic              rst;
    logic [32*NW-1:0]  stream;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              instr_ready;
    logic              instr_valid;
    logic [31:0]       instr;
    logic [31:0]       instr_pc;
    logic              fetch_done;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       fetch_count;
    logic [31:0]       stall_count;
    logic [15:0]       flush_count;
`endif

    int total = 0;
    int bad   = 0;

    instr_fetch_unit #(
        .NUM_WORDS  (NW),
        .FIFO_DEPTH (4),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .instruction_stream (stream),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .instr_ready        (instr_ready),
        .instr_valid        (instr_valid),
        .instr              (instr),
        .instr_pc           (instr_pc),
        .fetch_done         (fetch_done)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count        (fetch_count),
        .stall_count        (stall_count),
        .flush_count        (flush_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_of(input int i);
        case (i)
            0:       return 32'h2001_0002;
            1:       return 32'h0021_0820;
            2:       return 32'h2002_0007;
            default: return {16'hC0DE, 16'(i)};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_vld"}, 32'(instr_valid), 32'd1);
        check({tag, "_pc"}, instr_pc, pc);
        check({tag, "_ins"}, instr, word_of(int'(pc >> 2)));
    endtask

    initial begin
        for (int i = 0; i < NW; i++) stream[32*i +: 32] = word_of(i);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        #1;
        check("rst_vld",  32'(instr_valid), 32'd0);
        check("rst_ins",  instr,            32'd0);
        check("rst_pc",   instr_pc,         32'd0);
        check("rst_done", 32'(fetch_done),  32'd0);
        #1;
        rst = 1'b0;

        // Streaming with decode always ready: one instruction per cycle
        step();
        check_head("s0", 32'h0);
        step();
        check_head("s1", 32'h4);
        step();
        check_head("s2", 32'h8);

        // Backpressure: fill stops at 4, head is held, then drains in order
        do_reset();
        instr_ready = 1'b0;
        step(10);
        check_head("bp_hold", 32'h0);
        instr_ready = 1'b1;
        check_head("bp_r0", 32'h0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check_head("bp_r", 32'(4 * k));
        end

        // Redirect with three buffered entries; target is unaligned 0x19
        do_reset();
        instr_ready = 1'b0;
        step(3);
        check_head("rd_pre", 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0019;
        #1;
        check("rd_vld_now", 32'(instr_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        check("rd_vld_next", 32'(instr_valid), 32'd0);
        check("rd_pc_empty", instr_pc, 32'd0);
        step();
        check_head("rd_tgt", 32'h18);
        instr_ready = 1'b1;
        step();
        check_head("rd_tgt1", 32'h1C);

        // End of stream: last word, then done; redirect back resumes
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0FFC;
        step();
        redirect_valid = 1'b0;
        check("eos_vld0",  32'(instr_valid), 32'd0);
        check("eos_done0", 32'(fetch_done),  32'd0);
        step();
        check_head("eos_last", 32'hFFC);
        check("eos_done1", 32'(fetch_done), 32'd0);
        step();
        check("eos_vld2",  32'(instr_valid), 32'd0);
        check("eos_done2", 32'(fetch_done),  32'd1);
        step();
        check("eos_done3", 32'(fetch_done), 32'd1);
        check("eos_pc3",   instr_pc,        32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        check("eos_done4", 32'(fetch_done), 32'd0);
        step();
        check_head("eos_resume", 32'h0);

        // Asynchronous reset mid-stream with a full FIFO
        instr_ready = 1'b0;
        step(6);
        check_head("ar_full", 32'h0);
        rst = 1'b1;
        #1;
        check("ar_vld",  32'(instr_valid), 32'd0);
        check("ar_ins",  instr,            32'd0);
        check("ar_pc",   instr_pc,         32'd0);
        check("ar_done", 32'(fetch_done),  32'd0);
        step();
        rst = 1'b0;
        instr_ready = 1'b1;
        step();
        check_head("ar_first", 32'h0);

`ifdef FETCH_PERF_CNT_EN
        // Counters: 4 pushes, 5 stall cycles, 2 redirects
        do_reset();
        check("pc_fetch0", fetch_count, 32'd0);
        check("pc_stall0", stall_count, 32'd0);
        check("pc_flush0", 32'(flush_count), 32'd0);
        instr_ready = 1'b0;
        step(6);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step(2);
        redirect_valid = 1'b0;
        check("pc_fetch", fetch_count, 32'd4);
        check("pc_stall", stall_count, 32'd5);
        check("pc_flush", 32'(flush_count), 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
